// File: rtl/hsv_core_dmem_sram_if.sv
// AXI-style bus for the core data-memory port; the SRAM sits on the s side.
interface axib_if #(
   parameter int ID_W = 4
);
   logic            arvalid;
   logic            arready;
   logic [31:0]     araddr;
   logic [ID_W-1:0] arid;
   logic [7:0]      arlen;
   logic [2:0]      arsize;
   logic [1:0]      arburst;

   logic            awvalid;
   logic            awready;
   logic [31:0]     awaddr;
   logic [ID_W-1:0] awid;
   logic [7:0]      awlen;
   logic [2:0]      awsize;
   logic [1:0]      awburst;

   logic            wvalid;
   logic            wready;
   logic [31:0]     wdata;
   logic [3:0]      wstrb;
   logic            wlast;

   logic            rvalid;
   logic            rready;
   logic [31:0]     rdata;
   logic [1:0]      rresp;
   logic            rlast;
   logic [ID_W-1:0] rid;

   logic            bvalid;
   logic            bready;
   logic [1:0]      bresp;
   logic [ID_W-1:0] bid;

   modport s (
      input  arvalid, araddr, arid, arlen, arsize, arburst,
      input  awvalid, awaddr, awid, awlen, awsize, awburst,
      input  wvalid, wdata, wstrb, wlast,
      input  rready, bready,
      output arready, awready, wready,
      output rvalid, rdata, rresp, rlast, rid,
      output bvalid, bresp, bid
   );

   modport m (
      output arvalid, araddr, arid, arlen, arsize, arburst,
      output awvalid, awaddr, awid, awlen, awsize, awburst,
      output wvalid, wdata, wstrb, wlast,
      output rready, bready,
      input  arready, awready, wready,
      input  rvalid, rdata, rresp, rlast, rid,
      input  bvalid, bresp, bid
   );
endinterface

// File: rtl/hsv_core_dmem_sram.sv
// Single-beat AXI data SRAM: one transaction at a time, byte-lane writes,
// registered read data, DECERR for addresses outside the window.
module hsv_core_dmem_sram #(
   parameter int          DEPTH     = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
   input  logic clk_core,
   input  logic rst_core,
   axib_if.s    dmem
);
   localparam int          IW     = $clog2(DEPTH);
   localparam logic [32:0] SPAN   = 33'(DEPTH) * 33'd4;
   localparam logic [1:0]  OKAY   = 2'b00;
   localparam logic [1:0]  DECERR = 2'b11;

   typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_COLLECT, WR_RESP} state_t;

   state_t        state_reg;
   logic          last_grant_reg;
   logic          have_aw_reg;
   logic [IW-1:0] rd_idx_reg;
   logic [IW-1:0] wr_idx_reg;
   logic          rd_oor_reg;
   logic          wr_oor_reg;
   logic [31:0]   wdata_reg;
   logic [3:0]    wstrb_reg;
   logic          rvalid_reg;
   logic          bvalid_reg;
   logic [1:0]    rresp_reg;
   logic [1:0]    bresp_reg;
   logic [31:0]   rdata_word;

   logic [31:0]   ar_off;
   logic [31:0]   aw_off;
   logic          ar_oor;
   logic          aw_oor;
   logic          in_idle;
   logic          in_collect;
   logic          write_pending;
   logic          grant_rd;
   logic          grant_wr;
   logic          ar_rdy;
   logic          aw_rdy;
   logic          w_rdy;
   logic          ar_hs;
   logic          aw_hs;
   logic          w_hs;
   logic          wr_fire;
   logic [IW-1:0] wr_idx_eff;
   logic          wr_oor_eff;
   logic [31:0]   wdata_eff;
   logic [3:0]    wstrb_eff;
   logic          mem_we;
   logic          unused_fields;

   // Offsets wrap below BASE_ADDR, so one unsigned compare covers both bounds.
   assign ar_off = dmem.araddr - BASE_ADDR;
   assign aw_off = dmem.awaddr - BASE_ADDR;
   assign ar_oor = ({1'b0, ar_off} >= SPAN);
   assign aw_oor = ({1'b0, aw_off} >= SPAN);

   assign in_idle       = (state_reg == IDLE);
   assign in_collect    = (state_reg == WR_COLLECT);
   assign write_pending = dmem.awvalid | dmem.wvalid;
   assign grant_rd      = in_idle && dmem.arvalid && (!write_pending || last_grant_reg);
   assign grant_wr      = in_idle && write_pending && (!dmem.arvalid || !last_grant_reg);

   assign ar_rdy = !rst_core && grant_rd;
   assign aw_rdy = !rst_core && (grant_wr || (in_collect && !have_aw_reg));
   assign w_rdy  = !rst_core && (grant_wr || (in_collect && have_aw_reg));
   assign ar_hs  = ar_rdy && dmem.arvalid;
   assign aw_hs  = aw_rdy && dmem.awvalid;
   assign w_hs   = w_rdy && dmem.wvalid;

   // Write completes on whichever cycle the second of AW/W arrives.
   assign wr_fire    = (in_idle && aw_hs && w_hs) || (in_collect && (aw_hs || w_hs));
   assign wr_idx_eff = aw_hs ? aw_off[IW+1:2] : wr_idx_reg;
   assign wr_oor_eff = aw_hs ? aw_oor : wr_oor_reg;
   assign wdata_eff  = w_hs ? dmem.wdata : wdata_reg;
   assign wstrb_eff  = w_hs ? dmem.wstrb : wstrb_reg;
   assign mem_we     = wr_fire && !wr_oor_eff;

   assign unused_fields = ^{dmem.arid, dmem.arlen, dmem.arsize, dmem.arburst,
                            dmem.awid, dmem.awlen, dmem.awsize, dmem.awburst, dmem.wlast};

   assign dmem.arready = ar_rdy;
   assign dmem.awready = aw_rdy;
   assign dmem.wready  = w_rdy;
   assign dmem.rvalid  = rvalid_reg;
   assign dmem.rdata   = rdata_word;
   assign dmem.rresp   = rresp_reg;
   assign dmem.rlast   = 1'b1;
   assign dmem.rid     = '0;
   assign dmem.bvalid  = bvalid_reg;
   assign dmem.bresp   = bresp_reg;
   assign dmem.bid     = '0;

   always_ff @(posedge clk_core) begin
      if (rst_core) begin
         state_reg      <= IDLE;
         last_grant_reg <= 1'b1;
         have_aw_reg    <= 1'b0;
         rd_idx_reg     <= '0;
         wr_idx_reg     <= '0;
         rd_oor_reg     <= 1'b0;
         wr_oor_reg     <= 1'b0;
         wdata_reg      <= '0;
         wstrb_reg      <= '0;
         rvalid_reg     <= 1'b0;
         bvalid_reg     <= 1'b0;
         rresp_reg      <= OKAY;
         bresp_reg      <= OKAY;
      end else begin
         case (state_reg)
            IDLE: begin
               if (ar_hs) begin
                  rd_idx_reg     <= ar_off[IW+1:2];
                  rd_oor_reg     <= ar_oor;
                  last_grant_reg <= 1'b0;
                  state_reg      <= RD_WAIT;
               end else if (aw_hs && w_hs) begin
                  last_grant_reg <= 1'b1;
                  bvalid_reg     <= 1'b1;
                  bresp_reg      <= wr_oor_eff ? DECERR : OKAY;
                  state_reg      <= WR_RESP;
               end else if (aw_hs) begin
                  last_grant_reg <= 1'b1;
                  wr_idx_reg     <= aw_off[IW+1:2];
                  wr_oor_reg     <= aw_oor;
                  have_aw_reg    <= 1'b1;
                  state_reg      <= WR_COLLECT;
               end else if (w_hs) begin
                  last_grant_reg <= 1'b1;
                  wdata_reg      <= dmem.wdata;
                  wstrb_reg      <= dmem.wstrb;
                  have_aw_reg    <= 1'b0;
                  state_reg      <= WR_COLLECT;
               end
            end
            RD_WAIT: begin
               rvalid_reg <= 1'b1;
               rresp_reg  <= rd_oor_reg ? DECERR : OKAY;
               state_reg  <= RD_RESP;
            end
            RD_RESP: begin
               if (dmem.rready) begin
                  rvalid_reg <= 1'b0;
                  state_reg  <= IDLE;
               end
            end
            WR_COLLECT: begin
               if (wr_fire) begin
                  bvalid_reg <= 1'b1;
                  bresp_reg  <= wr_oor_eff ? DECERR : OKAY;
                  state_reg  <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (dmem.bready) begin
                  bvalid_reg <= 1'b0;
                  state_reg  <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // One byte-wide RAM per lane keeps the byte-enable write a plain array store.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] mem [DEPTH];
         logic [7:0] rd_byte_reg;

         always_ff @(posedge clk_core) begin
            if (mem_we && wstrb_eff[gi])
               mem[wr_idx_eff] <= wdata_eff[gi*8 +: 8];
            if (rst_core)
               rd_byte_reg <= '0;
            else if (state_reg == RD_WAIT)
               rd_byte_reg <= rd_oor_reg ? 8'h00 : mem[rd_idx_reg];
         end

         assign rdata_word[gi*8 +: 8] = rd_byte_reg;
      end
   endgenerate
endmodule

// File: tb/tb_hsv_core_dmem_sram.sv
// Scoreboard bench for hsv_core_dmem_sram: byte-addressed reference memory,
// expected responses queued at issue time and checked by a separate monitor.
module tb_hsv_core_dmem_sram;
   localparam int          DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h8000_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   axib_if bus ();

   hsv_core_dmem_sram #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk_core (clk),
      .rst_core (rst),
      .dmem     (bus)
   );

   typedef struct {
      bit          is_rd;
      logic [31:0] data;
      logic [1:0]  resp;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   logic [7:0]  ref_bytes [bit [31:0]];
   bit          tb_last_wr = 1'b1;
   int          vectors = 0;
   int          miscompares = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void note_fail(string name);
      vectors++;
      miscompares++;
      $display("FAIL %s at %0t", name, $time);
   endfunction

   function automatic bit ref_in_range(logic [31:0] a);
      return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + longint'(DEPTH) * 4);
   endfunction

   function automatic logic [31:0] ref_read(logic [31:0] a);
      logic [31:0] base_a;
      logic [31:0] r;
      base_a = {a[31:2], 2'b00};
      r = '0;
      for (int i = 0; i < 4; i++)
         if (ref_bytes.exists(base_a + 32'(i)))
            r[i*8 +: 8] = ref_bytes[base_a + 32'(i)];
      return r;
   endfunction

   function automatic void push_read(logic [31:0] a);
      exp_t e;
      e.is_rd = 1'b1;
      e.data  = ref_in_range(a) ? ref_read(a) : 32'h0;
      e.resp  = ref_in_range(a) ? 2'b00 : 2'b11;
      sb_q.push_back(e);
   endfunction

   function automatic void model_write(logic [31:0] a, logic [31:0] d, logic [3:0] s);
      exp_t        e;
      logic [31:0] base_a;
      base_a = {a[31:2], 2'b00};
      if (ref_in_range(a))
         for (int i = 0; i < 4; i++)
            if (s[i]) ref_bytes[base_a + 32'(i)] = d[i*8 +: 8];
      e.is_rd = 1'b0;
      e.data  = '0;
      e.resp  = ref_in_range(a) ? 2'b00 : 2'b11;
      sb_q.push_back(e);
   endfunction

   // Monitor: every completed R or B handshake consumes the oldest expectation.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.rvalid && bus.rready) begin
            if (sb_q.size() == 0 || !sb_q[0].is_rd) note_fail("unexpected_r");
            else begin
               mon_e = sb_q.pop_front();
               check("rdata", bus.rdata, mon_e.data);
               check("rresp", 32'(bus.rresp), 32'(mon_e.resp));
               check("rlast", 32'(bus.rlast), 32'd1);
               check("rid", 32'(bus.rid), 32'd0);
            end
         end
         if (bus.bvalid && bus.bready) begin
            if (sb_q.size() == 0 || sb_q[0].is_rd) note_fail("unexpected_b");
            else begin
               mon_e = sb_q.pop_front();
               check("bresp", 32'(bus.bresp), 32'(mon_e.resp));
               check("bid", 32'(bus.bid), 32'd0);
            end
         end
      end
   end

   // 0 arready, 1 awready&wready, 2 wready, 3 awready, 4 rvalid, 5 bvalid
   task automatic wait_cond(input int which, input int limit, output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      while (!ok && n < limit) begin
         @(negedge clk);
         n++;
         case (which)
            0:       ok = bus.arready;
            1:       ok = bus.awready && bus.wready;
            2:       ok = bus.wready;
            3:       ok = bus.awready;
            4:       ok = bus.rvalid;
            default: ok = bus.bvalid;
         endcase
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0) note_fail("resp_timeout");
   endtask

   task automatic do_read(input logic [31:0] addr, input int rdelay);
      int          n;
      bit          ok;
      logic [31:0] held;
      @(posedge clk); #1;
      bus.arvalid = 1'b1;
      bus.araddr  = addr;
      bus.arid    = 4'($urandom);
      bus.arlen   = 8'($urandom);
      bus.rready  = (rdelay == 0);
      wait_cond(0, 50, n, ok);
      if (!ok) note_fail("ar_timeout");
      else begin
         check("ar_grant_cycle", 32'(n), 32'd1);
         push_read(addr);
         tb_last_wr = 1'b0;
      end
      @(posedge clk); #1;
      bus.arvalid = 1'b0;
      wait_cond(4, 10, n, ok);
      check("r_latency", 32'(n), 32'd2);
      if (ok && rdelay > 0) begin
         held = bus.rdata;
         for (int k = 0; k < rdelay; k++) begin
            @(posedge clk); #1;
            bus.arvalid = 1'b1;
            @(negedge clk);
            check("rvalid_hold", 32'(bus.rvalid), 32'd1);
            check("rdata_hold", bus.rdata, held);
            check("arready_busy", 32'(bus.arready), 32'd0);
         end
         @(posedge clk); #1;
         bus.arvalid = 1'b0;
         bus.rready  = 1'b1;
         @(negedge clk);
      end
      @(posedge clk); #1;
      bus.rready = 1'b0;
   endtask

   // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W; 0: same cycle.
   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int lead);
      int n;
      bit ok;
      @(posedge clk); #1;
      bus.awaddr = addr;
      bus.wdata  = data;
      bus.wstrb  = strb;
      bus.awid   = 4'($urandom);
      bus.awlen  = 8'($urandom);
      bus.wlast  = 1'($urandom);
      if (lead == 0) begin
         bus.awvalid = 1'b1;
         bus.wvalid  = 1'b1;
         wait_cond(1, 50, n, ok);
      end else begin
         if (lead > 0) bus.wvalid = 1'b1;
         else          bus.awvalid = 1'b1;
         wait_cond((lead > 0) ? 2 : 3, 50, n, ok);
         if (!ok) note_fail("wr_first_timeout");
         @(posedge clk); #1;
         bus.wvalid  = 1'b0;
         bus.awvalid = 1'b0;
         for (int k = 0; k < ((lead > 0) ? lead : -lead); k++) begin
            @(negedge clk);
            check("collect_wready", 32'(bus.wready), (lead > 0) ? 32'd0 : 32'd1);
            check("collect_awready", 32'(bus.awready), (lead > 0) ? 32'd1 : 32'd0);
            check("collect_bvalid", 32'(bus.bvalid), 32'd0);
            @(posedge clk); #1;
         end
         if (lead > 0) bus.awvalid = 1'b1;
         else          bus.wvalid = 1'b1;
         wait_cond((lead > 0) ? 3 : 2, 5, n, ok);
      end
      if (!ok) note_fail("wr_timeout");
      else begin
         check("wr_grant_cycle", 32'(n), 32'd1);
         model_write(addr, data, strb);
         tb_last_wr = 1'b1;
      end
      @(posedge clk); #1;
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      wait_cond(5, 10, n, ok);
      check("b_latency", 32'(n), 32'd1);
      wait_drain();
   endtask

   // Read and full-word write to the same address raised in the same cycle.
   task automatic do_conflict(input logic [31:0] addr, input logic [31:0] data);
      int n;
      bit ok;
      bit rd_first;
      rd_first = tb_last_wr;
      @(posedge clk); #1;
      bus.arvalid = 1'b1;
      bus.araddr  = addr;
      bus.awvalid = 1'b1;
      bus.wvalid  = 1'b1;
      bus.awaddr  = addr;
      bus.wdata   = data;
      bus.wstrb   = 4'hF;
      bus.rready  = 1'b1;
      @(negedge clk);
      check("conf_arready", 32'(bus.arready), rd_first ? 32'd1 : 32'd0);
      check("conf_awready", 32'(bus.awready), rd_first ? 32'd0 : 32'd1);
      check("conf_wready", 32'(bus.wready), rd_first ? 32'd0 : 32'd1);
      if (rd_first) begin
         push_read(addr);
         @(posedge clk); #1;
         bus.arvalid = 1'b0;
         wait_cond(1, 60, n, ok);
         if (!ok) note_fail("conf_wr_timeout");
         else model_write(addr, data, 4'hF);
      end else begin
         model_write(addr, data, 4'hF);
         @(posedge clk); #1;
         bus.awvalid = 1'b0;
         bus.wvalid  = 1'b0;
         wait_cond(0, 60, n, ok);
         if (!ok) note_fail("conf_rd_timeout");
         else push_read(addr);
      end
      tb_last_wr = rd_first;
      @(posedge clk); #1;
      bus.arvalid = 1'b0;
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      wait_drain();
      @(posedge clk); #1;
      bus.rready = 1'b0;
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      tb_last_wr = 1'b1;
   endtask

   initial begin
      forever begin
         @(posedge clk); #1;
         bus.bready = rst ? 1'b1 : 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   initial begin
      int          n;
      bit          ok;
      logic [31:0] a;
      logic [31:0] oor_addr [3];

      bus.arvalid = 1'b1; bus.araddr = BASE; bus.arid = '0; bus.arlen = '0;
      bus.arsize  = 3'd2; bus.arburst = 2'd1;
      bus.awvalid = 1'b1; bus.awaddr = BASE; bus.awid = '0; bus.awlen = '0;
      bus.awsize  = 3'd2; bus.awburst = 2'd1;
      bus.wvalid  = 1'b1; bus.wdata = '0; bus.wstrb = 4'hF; bus.wlast = 1'b1;
      bus.rready  = 1'b0; bus.bready = 1'b1;

      repeat (3) @(negedge clk);
      check("rst_arready", 32'(bus.arready), 32'd0);
      check("rst_awready", 32'(bus.awready), 32'd0);
      check("rst_wready", 32'(bus.wready), 32'd0);
      check("rst_rvalid", 32'(bus.rvalid), 32'd0);
      check("rst_bvalid", 32'(bus.bvalid), 32'd0);
      check("rst_rresp", 32'(bus.rresp), 32'd0);
      check("rst_bresp", 32'(bus.bresp), 32'd0);
      check("rst_rdata", bus.rdata, 32'd0);
      @(posedge clk); #1;
      bus.arvalid = 1'b0;
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      rst = 1'b0;

      for (int w = 0; w < 16; w++) do_write(BASE + 32'(w * 4), $urandom, 4'hF, 0);
      do_write(BASE + 32'hFFC, 32'hA5A5_0FF0, 4'hF, 0);

      do_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
      do_read(BASE + 32'h10, 0);
      do_write(BASE + 32'h10, 32'h1122_3344, 4'b0101, 3);
      do_read(BASE + 32'h10, 0);
      do_read(BASE + 32'h1000, 0);
      do_write(32'h7FFF_FFFC, 32'h0BAD_F00D, 4'hF, 0);
      do_read(BASE + 32'hFFC, 0);
      do_read(BASE + 32'h20, 5);

      pulse_reset();
      do_read(BASE + 32'h10, 0);
      pulse_reset();
      do_conflict(BASE + 32'h24, 32'hCAFE_0001);
      do_conflict(BASE + 32'h24, 32'hCAFE_0002);
      do_read(BASE + 32'h28, 1);
      do_conflict(BASE + 32'h28, 32'hCAFE_0003);

      // W-only handshake, then reset while waiting for AW.
      @(posedge clk); #1;
      bus.wvalid = 1'b1;
      bus.wdata  = 32'hFFFF_FFFF;
      bus.wstrb  = 4'hF;
      wait_cond(2, 20, n, ok);
      if (!ok) note_fail("collect_w_timeout");
      @(posedge clk); #1;
      bus.wvalid  = 1'b0;
      bus.awvalid = 1'b1;
      bus.awaddr  = BASE + 32'h30;
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_awready", 32'(bus.awready), 32'd0);
      check("rst_mid_wready", 32'(bus.wready), 32'd0);
      @(posedge clk); #1;
      bus.awvalid = 1'b0;
      rst = 1'b0;
      tb_last_wr = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("rst_mid_bvalid", 32'(bus.bvalid), 32'd0);
      end
      do_read(BASE + 32'h30, 0);
      do_write(BASE + 32'h30, 32'h1357_9BDF, 4'hF, -2);
      do_read(BASE + 32'h30, 0);

      oor_addr[0] = BASE + 32'h1000;
      oor_addr[1] = BASE - 32'd4;
      oor_addr[2] = 32'h0000_0040;
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 7) == 0) a = oor_addr[$urandom_range(0, 2)] + 32'($urandom_range(0, 3) * 4);
         else                           a = BASE + 32'($urandom_range(0, 63));
         case ($urandom_range(0, 9))
            0, 1, 2, 3: do_read(a, $urandom_range(0, 3));
            4:          do_conflict(BASE + 32'($urandom_range(0, 15) * 4), $urandom);
            default:    do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 4) - 2);
         endcase
      end

      repeat (4) @(negedge clk);
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/hsv_core_dmem_sram.md
HSV_CORE_DMEM_SRAM -- requirements
Module: hsv_core_dmem_sram

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning the number of 32-bit words of storage (power of two, at least 4).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h8000_0000, meaning the byte address of word 0 (aligned to DEPTH*4).
REQ-003 SHALL have port clk_core, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_core, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port dmem, axib_if.s modport, AXI slave; it is the consumer of the data-memory master port of hsv_core_mem.
REQ-006 SHALL use these dmem fields: arvalid/arready/araddr; awvalid/awready/awaddr; wvalid/wready/wdata/wstrb; rvalid/rready/rdata/rresp/rlast/rid; bvalid/bready/bresp/bid.
REQ-007 SHALL ignore arid, arlen, arsize, arburst, awid, awlen, awsize, awburst and wlast; every transaction is treated as a single 4-byte beat.

Function
REQ-008 SHALL implement FSM states IDLE, RD_WAIT, RD_RESP, WR_COLLECT, WR_RESP; only one transaction is in service at a time.
REQ-009 Address decode SHALL be: in range iff BASE_ADDR <= addr < BASE_ADDR+DEPTH*4; word index = (addr-BASE_ADDR)[log2(DEPTH)+1:2]; addr[1:0] ignored.
REQ-010 In IDLE, grant SHALL be: read if arvalid and no write pending (awvalid|wvalid); write if a write is pending and arvalid=0; on conflict, the opposite of the last_grant register.
REQ-011 In IDLE with a read grant, arready SHALL be 1 and awready=wready=0; with a write grant, awready=wready=1 and arready=0; with nothing pending, all three SHALL be 0.
REQ-012 Read: AR handshake in cycle T SHALL latch the index, move to RD_WAIT in T+1, and assert rvalid in RD_RESP from T+2.
REQ-013 In RD_RESP, rdata/rresp SHALL be held stable with rvalid=1 until rready=1; the state then returns to IDLE the next cycle.
REQ-014 rlast SHALL equal 1 and rid SHALL equal 0 whenever rvalid=1.
REQ-015 rresp SHALL be OKAY (2'b00) for an in-range read; for an out-of-range read it SHALL be DECERR (2'b11) with rdata=0.
REQ-016 Write, same cycle: if AW and W both handshake in cycle T, the SRAM update SHALL occur at the end of T and bvalid SHALL assert in WR_RESP from T+1.
REQ-017 Write, split: if only one of AW/W handshakes, the state SHALL become WR_COLLECT with the captured channel's ready at 0 and the missing channel's ready at 1.
REQ-018 In WR_COLLECT, completion of the missing handshake in cycle T SHALL write at the end of T, with bvalid from T+1.
REQ-019 The write SHALL update byte lane i only where wstrb[i]=1; an out-of-range write SHALL modify nothing.
REQ-020 bresp SHALL be OKAY (in range) or DECERR (out of range); bid SHALL be 0; bvalid SHALL be held until bready=1, then the state returns to IDLE.
REQ-021 last_grant SHALL update on every IDLE grant; a non-conflict grant also updates it.
REQ-022 Responses SHALL NOT depend combinationally on rready/bready; a read followed by a write to the same word SHALL observe program order.

Reset
REQ-023 While rst_core=1: state IDLE; arready=awready=wready=rvalid=bvalid=0; rresp=bresp=0; rdata=0; last_grant=write.
REQ-024 Reset asserted mid-transaction SHALL abandon it with no response; any write already performed remains; SRAM contents are not cleared.
REQ-025 All readies SHALL be 0 during the cycle in which rst_core=1.

Verification
REQ-026 AW 0x8000_0010 + W 0xDEAD_BEEF strb 4'hF in the same cycle -> bvalid one cycle later, bresp=0; then AR 0x8000_0010 -> rvalid 2 cycles after AR handshake, rdata=0xDEAD_BEEF, rlast=1.
REQ-027 W (0x1122_3344, strb 4'b0101) 3 cycles before AW 0x8000_0010 -> WR_COLLECT holds wready=0/awready=1; readback of 0xDEAD_BEEF word = 0xDE22_BE44.
REQ-028 AR and AW/W asserted together from reset -> read granted first, write second; repeat the conflict -> read first again (alternation).
REQ-029 AR 0x8000_1000 (DEPTH=1024) -> rresp=2'b11, rdata=0; AW 0x7FFF_FFFC with W -> bresp=2'b11, memory unchanged.
REQ-030 rready held 0 for 5 cycles -> rvalid/rdata stable throughout, arready=0 until 1 cycle after the R handshake.
REQ-031 rst_core pulsed during WR_COLLECT -> bvalid never asserts; next transaction serviced normally.
